// File: rtl/edf_pkg.sv
// Shared types, defaults and the deadline-slice helper for the EDF interrupt arbiter.
package edf_pkg;

  localparam int unsigned NSRC_DEF     = 8;
  localparam int unsigned TS_WIDTH_DEF = 64;
  // Widest flattened deadline bus the slice helper accepts (64 sources of 64 bits).
  localparam int unsigned DL_BUS_MAX   = 4096;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REQ,
    SERVE
  } edf_arb_state_e;

  // Returns the 64-bit window starting at source k; callers truncate to their TsWidth.
  function automatic logic [63:0] dl_slice(input logic [DL_BUS_MAX-1:0] bus,
                                           input int unsigned           k,
                                           input int unsigned           ts_width);
    logic [DL_BUS_MAX-1:0] shifted;
    shifted = bus >> (k * ts_width);
    return shifted[63:0];
  endfunction

endpackage

// File: rtl/edf_min_track.sv
// Running-minimum register for the EDF scan: remembers the pending source with the
// smallest deadline seen since the last start pulse.
module edf_min_track
  import edf_pkg::*;
#(
  parameter int unsigned TsWidth = TS_WIDTH_DEF,
  parameter int unsigned IdWidth = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               en_i,
  input  logic               cand_valid_i,
  input  logic [IdWidth-1:0] cand_id_i,
  input  logic [TsWidth-1:0] cand_dl_i,
  output logic               found_o,
  output logic [IdWidth-1:0] win_id_o,
  output logic [TsWidth-1:0] win_dl_o
);

  logic               best_valid_q;
  logic [IdWidth-1:0] best_id_q;
  logic [TsWidth-1:0] best_dl_q;
  logic               take;

  // Strict less-than keeps the earlier (lower) index on equal deadlines.
  assign take = en_i && cand_valid_i && (!best_valid_q || (cand_dl_i < best_dl_q));

  // Winner including this cycle's candidate, so the last slot can be presented directly.
  assign found_o  = best_valid_q || take;
  assign win_id_o = take ? cand_id_i : best_id_q;
  assign win_dl_o = take ? cand_dl_i : best_dl_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      best_dl_q    <= '0;
    end else if (start_i) begin
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      best_dl_q    <= '0;
    end else if (take) begin
      best_valid_q <= 1'b1;
      best_id_q    <= cand_id_i;
      best_dl_q    <= cand_dl_i;
    end
  end

endmodule

// File: rtl/edf_arbiter.sv
// Earliest-deadline-first interrupt arbiter: sequential scan, present, claim, serve.
// Optional EDF_ARB_DLMISS_EN adds dl_miss_o, flagging a presented/serviced deadline already past mtime_i.
module edf_arbiter
  import edf_pkg::*;
#(
  parameter int unsigned NSrc    = NSRC_DEF,
  parameter int unsigned TsWidth = TS_WIDTH_DEF,
  parameter int unsigned IdWidth = $clog2(NSrc)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [63:0]             mtime_i,
  input  logic [NSrc-1:0]         ip_i,
  input  logic [NSrc*TsWidth-1:0] dl_i,
  output logic [NSrc-1:0]         claim_o,
  output logic                    irq_o,
  output logic [IdWidth-1:0]      irq_id_o,
  output logic [TsWidth-1:0]      irq_dl_o,
  input  logic                    irq_ack_i,
  input  logic                    irq_complete_i,
`ifdef EDF_ARB_DLMISS_EN
  output logic                    dl_miss_o,
`endif
  output logic                    busy_o
);

  localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NSrc - 1);

  edf_arb_state_e     state_q, state_d;
  logic [IdWidth-1:0] idx_q, idx_d;
  logic               irq_q, irq_d;
  logic [IdWidth-1:0] irq_id_q, irq_id_d;
  logic [TsWidth-1:0] irq_dl_q, irq_dl_d;
  logic [NSrc-1:0]    claim_q, claim_d;
  logic               busy_q, busy_d;

  logic               scan_start;
  logic               scan_en;
  logic               cand_valid;
  logic [TsWidth-1:0] cand_dl;
  logic               found;
  logic [IdWidth-1:0] win_id;
  logic [TsWidth-1:0] win_dl;

  assign cand_valid = ip_i[idx_q];
  assign cand_dl    = TsWidth'(dl_slice(DL_BUS_MAX'(dl_i), int'(idx_q), TsWidth));

  edf_min_track #(
    .TsWidth (TsWidth),
    .IdWidth (IdWidth)
  ) u_min_track (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (scan_start),
    .en_i         (scan_en),
    .cand_valid_i (cand_valid),
    .cand_id_i    (idx_q),
    .cand_dl_i    (cand_dl),
    .found_o      (found),
    .win_id_o     (win_id),
    .win_dl_o     (win_dl)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    irq_d      = irq_q;
    irq_id_d   = irq_id_q;
    irq_dl_d   = irq_dl_q;
    claim_d    = '0;
    scan_start = 1'b0;
    scan_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|ip_i) begin
          state_d    = SCAN;
          idx_d      = '0;
          scan_start = 1'b1;
        end
      end
      SCAN: begin
        scan_en = 1'b1;
        if (idx_q == LastIdx) begin
          if (found) begin
            state_d  = REQ;
            irq_d    = 1'b1;
            irq_id_d = win_id;
            irq_dl_d = win_dl;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      REQ: begin
        // Ack takes priority over a simultaneous withdraw.
        if (irq_ack_i) begin
          state_d = SERVE;
          irq_d   = 1'b0;
          claim_d = NSrc'(1) << irq_id_q;
        end else if (!ip_i[irq_id_q]) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      end
      SERVE: begin
        if (irq_complete_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase

    if (state_d == IDLE) begin
      irq_id_d = '0;
      irq_dl_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
      irq_dl_q <= '0;
      claim_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
      irq_dl_q <= irq_dl_d;
      claim_q  <= claim_d;
      busy_q   <= busy_d;
    end
  end

  assign claim_o  = claim_q;
  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;
  assign irq_dl_o = irq_dl_q;
  assign busy_o   = busy_q;

`ifdef EDF_ARB_DLMISS_EN
  logic dl_miss_q, dl_miss_d;

  // Evaluated against the deadline being registered so the flag is valid on the first REQ cycle.
  assign dl_miss_d = ((state_d == REQ) || (state_d == SERVE)) && (64'(irq_dl_d) < mtime_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dl_miss_q <= 1'b0;
    end else begin
      dl_miss_q <= dl_miss_d;
    end
  end

  assign dl_miss_o = dl_miss_q;
`else
  logic unused_mtime;
  assign unused_mtime = ^mtime_i;
`endif

endmodule

// File: tb/tb_edf_arbiter.sv
// Directed self-checking bench for edf_arbiter with four sources of 64-bit deadlines.
module tb_edf_arbiter;

  logic         clk;
  logic         rst_n;
  logic [63:0]  mtime;
  logic [3:0]   ip;
  logic [255:0] dl;
  logic [3:0]   claim;
  logic         irq;
  logic [1:0]   irq_id;
  logic [63:0]  irq_dl;
  logic         ack;
  logic         complete;
  logic         busy;
`ifdef EDF_ARB_DLMISS_EN
  logic         dl_miss;
`endif

  int total = 0;
  int bad   = 0;

  edf_arbiter #(
    .NSrc    (4),
    .TsWidth (64)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mtime_i        (mtime),
    .ip_i           (ip),
    .dl_i           (dl),
    .claim_o        (claim),
    .irq_o          (irq),
    .irq_id_o       (irq_id),
    .irq_dl_o       (irq_dl),
    .irq_ack_i      (ack),
    .irq_complete_i (complete),
`ifdef EDF_ARB_DLMISS_EN
    .dl_miss_o      (dl_miss),
`endif
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dl(input int k, input logic [63:0] v);
    dl[k*64 +: 64] = v;
  endtask

  // Ticks until irq rises; n is the number of edges taken, or -1 on timeout.
  task automatic wait_irq(output int n);
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (irq === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %0b want 0", irq); end
    total++; if (claim !== 4'b0000) begin bad++; $display("[TB] FAIL reset_claim: got %b want 0000", claim); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    total++; if (irq_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_id: got %0d want 0", irq_id); end
    total++; if (irq_dl !== 64'd0) begin bad++; $display("[TB] FAIL reset_dl: got %0d want 0", irq_dl); end
`ifdef EDF_ARB_DLMISS_EN
    total++; if (dl_miss !== 1'b0) begin bad++; $display("[TB] FAIL reset_dlmiss: got %0b want 0", dl_miss); end
`endif
    rst_n = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_single();
    int n;
    set_dl(2, 64'd500);
    ip = 4'b0100;
    wait_irq(n);
    total++; if (n != 5) begin bad++; $display("[TB] FAIL single_latency: got %0d want 5", n); end
    total++; if (irq_id !== 2'd2) begin bad++; $display("[TB] FAIL single_id: got %0d want 2", irq_id); end
    total++; if (irq_dl !== 64'd500) begin bad++; $display("[TB] FAIL single_dl: got %0d want 500", irq_dl); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_req: got %0b want 1", busy); end
    tick();
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL single_irq_hold: got %0b want 1", irq); end
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ip  = 4'b0000;
    total++; if (claim !== 4'b0100) begin bad++; $display("[TB] FAIL single_claim: got %b want 0100", claim); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL single_irq_drop: got %0b want 0", irq); end
    tick();
    total++; if (claim !== 4'b0000) begin bad++; $display("[TB] FAIL single_claim_once: got %b want 0000", claim); end
    tick();
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_serve_busy: got %0b want 1", busy); end
    total++; if (irq_id !== 2'd2) begin bad++; $display("[TB] FAIL single_serve_id: got %0d want 2", irq_id); end
    complete = 1'b1;
    tick();
    complete = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_complete: got %0b want 0", busy); end
  endtask

  task automatic test_edf_pick();
    int n;
    set_dl(0, 64'd400);
    set_dl(1, 64'd100);
    set_dl(2, 64'd300);
    set_dl(3, 64'd200);
    ip = 4'b1111;
    wait_irq(n);
    total++; if (n != 5) begin bad++; $display("[TB] FAIL pick_latency: got %0d want 5", n); end
    total++; if (irq_id !== 2'd1) begin bad++; $display("[TB] FAIL pick_id: got %0d want 1", irq_id); end
    total++; if (irq_dl !== 64'd100) begin bad++; $display("[TB] FAIL pick_dl: got %0d want 100", irq_dl); end
    ack = 1'b1;
    ip  = 4'b0000;
    tick();
    ack = 1'b0;
    total++; if (claim !== 4'b0010) begin bad++; $display("[TB] FAIL pick_claim: got %b want 0010", claim); end
    complete = 1'b1;
    tick();
    complete = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    int n;
    set_dl(0, 64'd0);
    set_dl(1, 64'd250);
    set_dl(2, 64'd0);
    set_dl(3, 64'd250);
    ip = 4'b1010;
    wait_irq(n);
    total++; if (n != 5) begin bad++; $display("[TB] FAIL tie_latency: got %0d want 5", n); end
    total++; if (irq_id !== 2'd1) begin bad++; $display("[TB] FAIL tie_id: got %0d want 1", irq_id); end
    total++; if (irq_dl !== 64'd250) begin bad++; $display("[TB] FAIL tie_dl: got %0d want 250", irq_dl); end
    ip = 4'b0000;
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL tie_withdraw: got %0b want 0", irq); end
    tick();
  endtask

  task automatic test_withdraw();
    int n;
    set_dl(0, 64'd300);
    set_dl(2, 64'd100);
    ip = 4'b0101;
    wait_irq(n);
    total++; if (irq_id !== 2'd2) begin bad++; $display("[TB] FAIL wd_first_id: got %0d want 2", irq_id); end
    ip = 4'b0001;
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL wd_irq_fall: got %0b want 0", irq); end
    total++; if (claim !== 4'b0000) begin bad++; $display("[TB] FAIL wd_no_claim: got %b want 0000", claim); end
    wait_irq(n);
    total++; if (n != 5) begin bad++; $display("[TB] FAIL wd_rescan_latency: got %0d want 5", n); end
    total++; if (irq_id !== 2'd0) begin bad++; $display("[TB] FAIL wd_rescan_id: got %0d want 0", irq_id); end
    total++; if (irq_dl !== 64'd300) begin bad++; $display("[TB] FAIL wd_rescan_dl: got %0d want 300", irq_dl); end
    ip = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_ack_withdraw();
    int n;
    set_dl(3, 64'd700);
    ip = 4'b1000;
    wait_irq(n);
    total++; if (irq_id !== 2'd3) begin bad++; $display("[TB] FAIL aw_id: got %0d want 3", irq_id); end
    ack = 1'b1;
    ip  = 4'b0000;
    tick();
    ack = 1'b0;
    total++; if (claim !== 4'b1000) begin bad++; $display("[TB] FAIL aw_claim: got %b want 1000", claim); end
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++; if (claim !== 4'b0000) begin bad++; $display("[TB] FAIL aw_spurious_claim: got %b want 0000", claim); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL aw_serve_busy: got %0b want 1", busy); end
    total++; if (irq_id !== 2'd3) begin bad++; $display("[TB] FAIL aw_serve_id: got %0d want 3", irq_id); end
    complete = 1'b1;
    tick();
    complete = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL aw_complete: got %0b want 0", busy); end
    tick();
  endtask

  task automatic test_reset_midway();
    int n;
    set_dl(1, 64'd40);
    set_dl(2, 64'd90);
    ip = 4'b0110;
    tick();
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rst_scan_busy: got %0b want 1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_scan_busy_clr: got %0b want 0", busy); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL rst_scan_irq: got %0b want 0", irq); end
    tick();
    rst_n = 1'b1;
    wait_irq(n);
    total++; if (irq_id !== 2'd1) begin bad++; $display("[TB] FAIL rst_req_id: got %0d want 1", irq_id); end
    rst_n = 1'b0;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL rst_req_irq: got %0b want 0", irq); end
    total++; if (irq_id !== 2'd0) begin bad++; $display("[TB] FAIL rst_req_id_clr: got %0d want 0", irq_id); end
    total++; if (irq_dl !== 64'd0) begin bad++; $display("[TB] FAIL rst_req_dl_clr: got %0d want 0", irq_dl); end
    ip = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (claim !== 4'b0000) begin bad++; $display("[TB] FAIL rst_no_claim: got %b want 0000", claim); end
  endtask

`ifdef EDF_ARB_DLMISS_EN
  task automatic test_dlmiss();
    int n;
    set_dl(0, 64'd100);
    mtime = 64'd150;
    ip    = 4'b0001;
    wait_irq(n);
    total++; if (dl_miss !== 1'b1) begin bad++; $display("[TB] FAIL dlmiss_req: got %0b want 1", dl_miss); end
    ip = 4'b0000;
    tick();
    total++; if (dl_miss !== 1'b0) begin bad++; $display("[TB] FAIL dlmiss_idle: got %0b want 0", dl_miss); end
    mtime = 64'd50;
    ip    = 4'b0001;
    wait_irq(n);
    total++; if (dl_miss !== 1'b0) begin bad++; $display("[TB] FAIL dlmiss_ontime: got %0b want 0", dl_miss); end
    ip = 4'b0000;
    tick();
    tick();
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    mtime    = 64'd0;
    ip       = 4'b0000;
    dl       = '0;
    ack      = 1'b0;
    complete = 1'b0;
    tick();
    tick();
    test_reset();
    test_single();
    test_edf_pick();
    test_tie();
    test_withdraw();
    test_ack_withdraw();
    test_reset_midway();
`ifdef EDF_ARB_DLMISS_EN
    test_dlmiss();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
